// File: rtl/bsg_host_support_pkg.sv
// bsg_host_support_pkg: shared constants for the host support block
package bsg_host_support_pkg;
  localparam int gpio_trace_en_idx_gp = 0;
  localparam int gpio_log_en_idx_gp   = 1;
  localparam int ctr_width_gp         = 64;
endpackage

// File: rtl/bsg_host_support_ctrl_if.sv
// bsg_host_support_ctrl_if: host GPIO write/readback bus
interface bsg_host_support_ctrl_if #(parameter int gpio_width_p = 2);
  logic                    gpio_w_v_i;
  logic [gpio_width_p-1:0] gpio_w_data_i;
  logic [gpio_width_p-1:0] gpio_o;
  logic [gpio_width_p-1:0] gpio_i;
  logic [gpio_width_p-1:0] gpio_r_data_o;
  modport master (output gpio_w_v_i, gpio_w_data_i, gpio_i, input gpio_o, gpio_r_data_o);
  modport slave (input gpio_w_v_i, gpio_w_data_i, gpio_i, output gpio_o, gpio_r_data_o);
endinterface

// File: rtl/bsg_host_delay_chain.sv
// bsg_host_delay_chain: resettable flop chain, zero stages is a pass-through
module bsg_host_delay_chain #(
  parameter int width_p  = 1,
  parameter int stages_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);
  if (stages_p == 0) begin : g_pass
    assign data_o = data_i;
  end else begin : g_chain
    logic [width_p-1:0] r [stages_p];
    always_ff @(posedge clk_i)
      if (!reset_n_i)
        r <= '{default: '0};
      else begin
        r[0] <= data_i;
        for (int k = 1; k < stages_p; k++)
          r[k] <= r[k-1];
      end
    assign data_o = r[stages_p-1];
  end
endmodule

// File: rtl/bsg_host_support_ctrl.sv
// bsg_host_support_ctrl: reset-done delay chain, free-running cycle counter
// and host-writable GPIO register for the manycore testbench top
module bsg_host_support_ctrl
  import bsg_host_support_pkg::*;
#(
  parameter int                    chain_stages_p    = 3,
  parameter int                    ctr_width_p       = ctr_width_gp,
  parameter int                    gpio_width_p      = 2,
  parameter logic [gpio_width_p-1:0] gpio_init_p     = '0,
  parameter bit                    gpio_use_output_p = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   tag_done_i,
  output logic                   tag_done_r_o,
  output logic [ctr_width_p-1:0] ctr_r_o,
  bsg_host_support_ctrl_if.slave gpio
);
  bsg_host_delay_chain #(.width_p(1), .stages_p(chain_stages_p)) chain (
    .clk_i,
    .reset_n_i,
    .data_i(tag_done_i),
    .data_o(tag_done_r_o)
  );
  always_ff @(posedge clk_i)
    ctr_r_o <= !reset_n_i ? '0 : ctr_r_o + {{(ctr_width_p-1){1'b0}}, 1'b1};
  always_ff @(posedge clk_i)
    if (!reset_n_i)
      gpio.gpio_o <= gpio_init_p;
    else if (gpio.gpio_w_v_i)
      gpio.gpio_o <= gpio.gpio_w_data_i;
  assign gpio.gpio_r_data_o = gpio_use_output_p ? gpio.gpio_o : gpio.gpio_i;
endmodule

// File: tb/tb_bsg_host_support_ctrl.sv
// tb_bsg_host_support_ctrl: two configurations driven in lockstep and checked
// against a history-based model of the chain, counter and GPIO rules
module tb_bsg_host_support_ctrl;
  logic clk = 1'b0;
  logic reset_n, tag_done;
  logic tag_a, tag_b;
  logic [63:0] ctr_a;
  logic [3:0] ctr_b;
  int total = 0;
  int bad = 0;
  longint unsigned m = 0;
  logic [1:0] gpio_a_exp = 2'b00;
  logic [1:0] gpio_b_exp = 2'b01;
  logic tq [3] = '{1'b0, 1'b0, 1'b0};
  logic rq [3] = '{1'b0, 1'b0, 1'b0};
  always #5 clk = ~clk;
  bsg_host_support_ctrl_if #(.gpio_width_p(2)) ifa ();
  bsg_host_support_ctrl_if #(.gpio_width_p(2)) ifb ();
  bsg_host_support_ctrl #(
    .chain_stages_p(3), .ctr_width_p(64), .gpio_width_p(2),
    .gpio_init_p(2'b00), .gpio_use_output_p(1'b1)
  ) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .tag_done_i(tag_done),
    .tag_done_r_o(tag_a), .ctr_r_o(ctr_a), .gpio(ifa.slave)
  );
  bsg_host_support_ctrl #(
    .chain_stages_p(0), .ctr_width_p(4), .gpio_width_p(2),
    .gpio_init_p(2'b01), .gpio_use_output_p(1'b0)
  ) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .tag_done_i(tag_done),
    .tag_done_r_o(tag_b), .ctr_r_o(ctr_b), .gpio(ifb.slave)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // One clock: drive inputs, apply the model at the edge, check at the falling edge.
  task automatic cyc(input logic rn, input logic td, input logic wv, input logic [1:0] wd, input logic [1:0] gi);
    logic exp_tag;
    reset_n = rn;
    tag_done = td;
    ifa.gpio_w_v_i = wv; ifa.gpio_w_data_i = wd; ifa.gpio_i = gi;
    ifb.gpio_w_v_i = wv; ifb.gpio_w_data_i = wd; ifb.gpio_i = gi;
    @(posedge clk);
    if (!rn) begin
      m = 0;
      gpio_a_exp = 2'b00;
      gpio_b_exp = 2'b01;
    end else begin
      m++;
      if (wv) begin
        gpio_a_exp = wd;
        gpio_b_exp = wd;
      end
    end
    tq[2] = tq[1]; tq[1] = tq[0]; tq[0] = td;
    rq[2] = rq[1]; rq[1] = rq[0]; rq[0] = rn;
    // Output after edge n is the input of edge n-2, unless any of those three edges was in reset.
    exp_tag = tq[2] & rq[2] & rq[1] & rq[0];
    @(negedge clk);
    check("ctr_a", ctr_a, m);
    check("ctr_b", {60'd0, ctr_b}, m % 16);
    check("tag_a", {63'd0, tag_a}, {63'd0, exp_tag});
    check("tag_b", {63'd0, tag_b}, {63'd0, td});
    check("gpio_a", {62'd0, ifa.gpio_o}, {62'd0, gpio_a_exp});
    check("rd_a", {62'd0, ifa.gpio_r_data_o}, {62'd0, gpio_a_exp});
    check("gpio_b", {62'd0, ifb.gpio_o}, {62'd0, gpio_b_exp});
    check("rd_b", {62'd0, ifb.gpio_r_data_o}, {62'd0, gi});
  endtask
  initial begin
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 2'b00, 2'b10);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 2'b00, 2'b10);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 2'b00, 2'b01);
    cyc(1'b1, 1'b1, 1'b0, 2'b00, 2'b01);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 2'b00, 2'b11);
    cyc(1'b1, 1'b0, 1'b1, 2'b01, 2'b10);
    cyc(1'b1, 1'b0, 1'b1, 2'b11, 2'b10);
    while (m < 100) cyc(1'b1, 1'b1, 1'b0, 2'b00, 2'b10);
    cyc(1'b0, 1'b1, 1'b1, 2'b01, 2'b10);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 2'b00, 2'b10);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 19) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
          2'($urandom), 2'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
